biquad_cascade_sched: RTL and testbench
=======================================

// Module: biquad_cascade_sched
// PURPOSE
//  Schedules one shared time-multiplexed biquad engine across NUM_STAGES cascaded EQ stages.
//  Per stage it owns the coefficient bank and history (x1,x2,y1,y2), issues one engine job,
//  captures the result and chains it into the next stage. Sits between the audio sample
//  source and the single-DSP biquad engine. Coefficient updates are double-buffered and
//  commit only on sample boundaries.
// PARAMETERS
//  NUM_STAGES  4        cascaded biquad stages sharing the engine (1..8)
//  STAGE_W     2        width of stage index, $clog2(NUM_STAGES), min 1
//  RESET_B0    16'h4000 b0 reset value (unity in Q2.14); all other coefficients reset to 0
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high
//  sample_valid  in   1       1-cycle strobe, new input sample
//  sample_in     in   16      signed x[n] into stage 0
//  coef_we       in   1       write one shadow coefficient
//  coef_stage    in   STAGE_W target stage of the write
//  coef_sel      in   3       0=b0 1=b1 2=b2 3=a1 4=a2; 5-7 ignored
//  coef_data     in   16      signed coefficient value
//  coef_commit   in   1       1-cycle strobe: copy shadow bank to active bank
//  eng_start     out  1       1-cycle strobe, engine job launch
//  eng_x         out  16      current stage input
//  eng_hist      out  64      {x1,x2,y1,y2} of current stage
//  eng_coef      out  80      {b0,b1,b2,a1,a2} from active bank, current stage
//  eng_y         in   16      engine result
//  eng_done      in   1       1-cycle strobe, eng_y valid
//  filtered_out  out  16      last-stage output
//  output_valid  out  1       1-cycle strobe with filtered_out
//  busy          out  1       high from accepted sample until output_valid cycle inclusive
//  overrun       out  1       sticky: sample_valid arrived while busy
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; all histories 0; active and shadow banks = {RESET_B0,0,0,0,0};
//    commit_pending=0. Reset in any state aborts the job in one cycle; later eng_done ignored.
//  - FSM: IDLE -> ISSUE on sample_valid (latch sample_in to stage input, stage=0, busy=1).
//    ISSUE: assert eng_start one cycle with eng_x/eng_hist/eng_coef of stage -> WAIT.
//    WAIT: hold eng_* stable; on eng_done -> STORE. STORE: x2<=x1, x1<=x, y2<=y1, y1<=eng_y
//    for the stage; stage input <= eng_y; last stage -> DONE, else stage+1 -> ISSUE.
//    DONE: filtered_out<=last y, output_valid=1 -> IDLE.
//  - Latency sample_valid->output_valid = NUM_STAGES*(3+L_eng)+2 cycles,
//    L_eng = cycles eng_start->eng_done.
//  - eng_done outside WAIT ignored. No engine timeout.
//  - sample_valid when not IDLE: sample dropped, overrun<=1 (sticky until reset), job unaffected.
//  - coef_we: writes shadow any cycle; coef_sel>=5 or coef_stage>=NUM_STAGES ignored.
//  - coef_commit in IDLE: copy that cycle; simultaneous sample_valid uses new coefs.
//    coef_commit while busy: commit_pending=1; copy on DONE->IDLE; never mid-sample.
//  - coef_we and commit in same cycle: the write is included in the committed copy.
//  - Histories persist across samples; never cleared except by reset.
//  - filtered_out holds until next output_valid.
// STRUCTURE
//  - biquad_pkg: sched_state_t {IDLE,ISSUE,WAIT,STORE,DONE}; COEF_B0..COEF_A2 index
//    constants; coef_set_t packed struct {b0,b1,b2,a1,a2}.
//  - Sub-module biquad_coef_bank: shadow+active arrays, write port, commit copy, read mux
//    by stage. Histories and FSM stay in this module.
// TESTING (engine model: y = sat16((b0*x+b1*x1+b2*x2-a1*y1-a2*y2)>>>14), L_eng=3)
//  - Reset, NUM_STAGES=2, sample 0x1000 -> filtered_out=0x1000, output_valid at cycle 14, busy low after.
//  - Write stage1 b0=0x2000, commit in IDLE, sample 0x1000 -> filtered_out=0x0800.
//  - Commit of stage0 b0=0x2000 during WAIT -> current sample out 0x1000; next sample out 0x0800.
//  - sample_valid while busy -> overrun=1, output of first sample unchanged, no second job.
//  - Stage0 b1=0x4000, impulse 0x1000 then 0 -> outputs 0x1000, 0x1000, then 0.
//  - reset asserted in WAIT -> next cycle busy=0, eng_start=0; late eng_done no output_valid.

Source files
------------

// File: rtl/biquad_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade scheduler.
package biquad_pkg;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // Coefficient select encoding on coef_sel
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  // One stage's coefficient set; b0 occupies the most significant slice
  typedef struct packed {
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] b2;
    logic [15:0] a1;
    logic [15:0] a2;
  } coef_set_t;

  // Pass-through coefficient set: b0 as given, everything else zero
  function automatic coef_set_t coef_reset_set(input logic [15:0] b0_val);
    coef_set_t c;
    c.b0 = b0_val;
    c.b1 = 16'h0000;
    c.b2 = 16'h0000;
    c.a1 = 16'h0000;
    c.a2 = 16'h0000;
    return c;
  endfunction

endpackage

// File: rtl/biquad_coef_bank.sv
// Double-buffered coefficient storage: per-stage shadow bank written by the host,
// active bank read by the scheduler. The active bank only changes on a commit pulse.
module biquad_coef_bank
  import biquad_pkg::*;
#(
  parameter int          NUM_STAGES = 4,
  parameter int          STAGE_W    = 2,
  parameter logic [15:0] RESET_B0   = 16'h4000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coef_we,
  input  logic [STAGE_W-1:0] coef_stage,
  input  logic [2:0]         coef_sel,
  input  logic [15:0]        coef_data,
  input  logic               commit,
  input  logic [STAGE_W-1:0] rd_stage,
  output coef_set_t          rd_coef
);

  coef_set_t shadow_r    [NUM_STAGES];
  coef_set_t active_r    [NUM_STAGES];
  coef_set_t shadow_next_s [NUM_STAGES];
  logic      wr_ok_s;

  assign wr_ok_s = coef_we && (int'(coef_stage) < NUM_STAGES);

  // Shadow bank with this cycle's write folded in, so a same-cycle commit sees it
  always_comb begin
    shadow_next_s = shadow_r;
    if (wr_ok_s) begin
      case (coef_sel)
        COEF_B0: shadow_next_s[coef_stage].b0 = coef_data;
        COEF_B1: shadow_next_s[coef_stage].b1 = coef_data;
        COEF_B2: shadow_next_s[coef_stage].b2 = coef_data;
        COEF_A1: shadow_next_s[coef_stage].a1 = coef_data;
        COEF_A2: shadow_next_s[coef_stage].a2 = coef_data;
        default: shadow_next_s = shadow_r;
      endcase
    end else begin
      shadow_next_s = shadow_r;
    end
  end

  // Shadow capture every cycle; active bank copies the shadow only on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        shadow_r[i] <= coef_reset_set(RESET_B0);
        active_r[i] <= coef_reset_set(RESET_B0);
      end
    end else begin
      shadow_r <= shadow_next_s;
      if (commit) begin
        active_r <= shadow_next_s;
      end
    end
  end

  assign rd_coef = active_r[rd_stage];

endmodule

// File: rtl/biquad_cascade_sched.sv
// Schedules one shared biquad engine across NUM_STAGES cascaded stages. Owns the
// per-stage histories, issues one engine job per stage and chains each result
// into the next stage. Coefficient commits land only on sample boundaries.
module biquad_cascade_sched
  import biquad_pkg::*;
#(
  parameter int          NUM_STAGES = 4,
  parameter int          STAGE_W    = 2,
  parameter logic [15:0] RESET_B0   = 16'h4000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [15:0]        sample_in,
  input  logic               coef_we,
  input  logic [STAGE_W-1:0] coef_stage,
  input  logic [2:0]         coef_sel,
  input  logic [15:0]        coef_data,
  input  logic               coef_commit,
  output logic               eng_start,
  output logic [15:0]        eng_x,
  output logic [63:0]        eng_hist,
  output logic [79:0]        eng_coef,
  input  logic [15:0]        eng_y,
  input  logic               eng_done,
  output logic [15:0]        filtered_out,
  output logic               output_valid,
  output logic               busy,
  output logic               overrun
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  sched_state_t       state_r;
  logic [STAGE_W-1:0] stage_r;
  logic [15:0]        stage_x_r;
  logic [15:0]        y_cap_r;
  logic               commit_pending_r;
  logic               commit_now_s;
  coef_set_t          rd_coef_s;

  logic [15:0] x1_r [NUM_STAGES];
  logic [15:0] x2_r [NUM_STAGES];
  logic [15:0] y1_r [NUM_STAGES];
  logic [15:0] y2_r [NUM_STAGES];

  // Commit immediately when idle; a deferred commit lands as DONE hands back to IDLE
  always_comb begin
    commit_now_s = 1'b0;
    if (state_r == IDLE) begin
      commit_now_s = coef_commit;
    end else if (state_r == DONE) begin
      commit_now_s = coef_commit | commit_pending_r;
    end else begin
      commit_now_s = 1'b0;
    end
  end

  biquad_coef_bank #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W),
    .RESET_B0   (RESET_B0)
  ) u_coef_bank (
    .clk        (clk),
    .reset      (reset),
    .coef_we    (coef_we),
    .coef_stage (coef_stage),
    .coef_sel   (coef_sel),
    .coef_data  (coef_data),
    .commit     (commit_now_s),
    .rd_stage   (stage_r),
    .rd_coef    (rd_coef_s)
  );

  // Scheduler FSM: sample accept, per-stage engine job, history update, output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      stage_r          <= {STAGE_W{1'b0}};
      stage_x_r        <= 16'h0000;
      y_cap_r          <= 16'h0000;
      commit_pending_r <= 1'b0;
      eng_start        <= 1'b0;
      eng_x            <= 16'h0000;
      eng_hist         <= 64'h0;
      eng_coef         <= 80'h0;
      filtered_out     <= 16'h0000;
      output_valid     <= 1'b0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        x1_r[i] <= 16'h0000;
        x2_r[i] <= 16'h0000;
        y1_r[i] <= 16'h0000;
        y2_r[i] <= 16'h0000;
      end
    end else begin
      eng_start    <= 1'b0;
      output_valid <= 1'b0;

      // A sample arriving mid-job is dropped and flagged, the job carries on
      if (sample_valid && (state_r != IDLE)) begin
        overrun <= 1'b1;
      end

      // Commit requested mid-job is remembered until the sample completes
      if (coef_commit && (state_r != IDLE) && (state_r != DONE)) begin
        commit_pending_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (sample_valid) begin
            stage_x_r <= sample_in;
            stage_r   <= {STAGE_W{1'b0}};
            busy      <= 1'b1;
            state_r   <= ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        ISSUE: begin
          eng_start <= 1'b1;
          eng_x     <= stage_x_r;
          eng_hist  <= {x1_r[stage_r], x2_r[stage_r], y1_r[stage_r], y2_r[stage_r]};
          eng_coef  <= rd_coef_s;
          state_r   <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            y_cap_r <= eng_y;
            state_r <= STORE;
          end
        end
        STORE: begin
          x2_r[stage_r] <= x1_r[stage_r];
          x1_r[stage_r] <= stage_x_r;
          y2_r[stage_r] <= y1_r[stage_r];
          y1_r[stage_r] <= y_cap_r;
          stage_x_r     <= y_cap_r;
          if (stage_r == LAST_STAGE) begin
            state_r <= DONE;
          end else begin
            stage_r <= stage_r + STAGE_W'(1);
            state_r <= ISSUE;
          end
        end
        DONE: begin
          filtered_out     <= stage_x_r;
          output_valid     <= 1'b1;
          commit_pending_r <= 1'b0;
          state_r          <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_biquad_cascade_sched.sv
// Self-checking bench for biquad_cascade_sched with a 2-stage cascade, a
// fixed-latency engine stand-in and a per-stage difference-equation reference.
module tb_biquad_cascade_sched;

  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        coef_we = 1'b0;
  logic [0:0]  coef_stage = 1'b0;
  logic [2:0]  coef_sel = 3'd0;
  logic [15:0] coef_data = 16'h0000;
  logic        coef_commit = 1'b0;
  logic        eng_start;
  logic [15:0] eng_x;
  logic [63:0] eng_hist;
  logic [79:0] eng_coef;
  logic [15:0] eng_y = 16'h0000;
  logic        eng_done = 1'b0;
  logic [15:0] filtered_out;
  logic        output_valid;
  logic        busy;
  logic        overrun;

  biquad_cascade_sched #(.NUM_STAGES(NS), .STAGE_W(1), .RESET_B0(16'h4000)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .coef_we(coef_we), .coef_stage(coef_stage), .coef_sel(coef_sel),
    .coef_data(coef_data), .coef_commit(coef_commit), .eng_start(eng_start),
    .eng_x(eng_x), .eng_hist(eng_hist), .eng_coef(eng_coef), .eng_y(eng_y),
    .eng_done(eng_done), .filtered_out(filtered_out), .output_valid(output_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference state: coefficient banks [stage][b0,b1,b2,a1,a2] and histories
  logic [15:0] ref_act [NS][5];
  logic [15:0] ref_sh  [NS][5];
  logic [15:0] rx1 [NS];
  logic [15:0] rx2 [NS];
  logic [15:0] ry1 [NS];
  logic [15:0] ry2 [NS];

  int          eng_cnt = 0;
  logic [15:0] eng_res = 16'h0000;
  int          start_cnt = 0;

  function automatic logic [15:0] bq(input logic [15:0] b0, b1, b2, a1, a2,
                                     input logic [15:0] x, x1, x2, y1, y2);
    longint acc;
    acc = longint'($signed(b0)) * longint'($signed(x))
        + longint'($signed(b1)) * longint'($signed(x1))
        + longint'($signed(b2)) * longint'($signed(x2))
        - longint'($signed(a1)) * longint'($signed(y1))
        - longint'($signed(a2)) * longint'($signed(y2));
    acc = acc >>> 14;
    if (acc > 64'sd32767) acc = 64'sd32767;
    else if (acc < -64'sd32768) acc = -64'sd32768;
    return 16'(acc);
  endfunction

  function automatic logic [15:0] ref_run(input logic [15:0] xin);
    logic [15:0] x, y;
    x = xin;
    for (int s = 0; s < NS; s++) begin
      y = bq(ref_act[s][0], ref_act[s][1], ref_act[s][2], ref_act[s][3], ref_act[s][4],
             x, rx1[s], rx2[s], ry1[s], ry2[s]);
      rx2[s] = rx1[s]; rx1[s] = x;
      ry2[s] = ry1[s]; ry1[s] = y;
      x = y;
    end
    return x;
  endfunction

  task automatic ref_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 5; k++) begin
        ref_act[s][k] = (k == 0) ? 16'h4000 : 16'h0000;
        ref_sh[s][k]  = (k == 0) ? 16'h4000 : 16'h0000;
      end
      rx1[s] = 16'h0000; rx2[s] = 16'h0000; ry1[s] = 16'h0000; ry2[s] = 16'h0000;
    end
  endtask

  task automatic ref_commit();
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < 5; k++) ref_act[s][k] = ref_sh[s][k];
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock; then the engine stand-in reacts (eng_done 3 cycles after eng_start)
  task automatic step();
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_y = eng_res;
      end
    end
    if (eng_start) begin
      start_cnt++;
      eng_cnt = 3;
      eng_res = bq(eng_coef[79:64], eng_coef[63:48], eng_coef[47:32], eng_coef[31:16],
                   eng_coef[15:0], eng_x, eng_hist[63:48], eng_hist[47:32],
                   eng_hist[31:16], eng_hist[15:0]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
    step(); step();
    reset = 1'b0;
    ref_reset();
  endtask

  task automatic idle_write(input bit we, input logic [0:0] st, input logic [2:0] sel,
                            input logic [15:0] data, input bit commit);
    coef_we = we; coef_stage = st; coef_sel = sel; coef_data = data; coef_commit = commit;
    step();
    coef_we = 1'b0; coef_commit = 1'b0;
    if (we && sel < 3'd5) ref_sh[st][sel] = data;
    if (commit) ref_commit();
  endtask

  // one sample through the cascade; optional write/commit/extra sample during WAIT
  task automatic do_sample(input logic [15:0] x, input bit mid_we, input logic [0:0] mst,
                           input logic [2:0] msel, input logic [15:0] mdata,
                           input bit mid_commit, input bit mid_sv, input string tag);
    logic [15:0] exp_y;
    int lat, s0;
    bit found;
    exp_y = ref_run(x);
    s0 = start_cnt;
    sample_in = x; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    lat = 1; found = 1'b0;
    while (lat <= 40 && !found) begin
      if (output_valid) begin
        found = 1'b1;
      end else begin
        if (lat == 4) begin
          coef_we = mid_we; coef_stage = mst; coef_sel = msel; coef_data = mdata;
          coef_commit = mid_commit;
          if (mid_sv) begin sample_valid = 1'b1; sample_in = ~x; end
          check({tag, "_busy_mid"}, 80'(busy), 80'd1);
        end
        step();
        coef_we = 1'b0; coef_commit = 1'b0; sample_valid = 1'b0;
        lat++;
      end
    end
    check({tag, "_latency"}, 80'(lat), 80'd14);
    check({tag, "_out"}, 80'(filtered_out), 80'(exp_y));
    check({tag, "_jobs"}, 80'(start_cnt - s0), 80'(NS));
    step();
    check({tag, "_busy_after"}, 80'(busy), 80'd0);
    if (mid_we && msel < 3'd5) ref_sh[mst][msel] = mdata;
    if (mid_commit) ref_commit();
  endtask

  initial begin
    int ov;
    bit found;
    logic [15:0] rc;

    // reset state
    do_reset();
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_ovalid", 80'(output_valid), 80'd0);
    check("rst_start", 80'(eng_start), 80'd0);
    check("rst_fout", 80'(filtered_out), 80'd0);
    check("rst_overrun", 80'(overrun), 80'd0);
    check("rst_coef", eng_coef, 80'd0);

    // unity cascade
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "unity");
    check("unity_const", 80'(filtered_out), 80'h1000);

    // stage1 b0 = 0.5, written and committed together in IDLE
    idle_write(1'b1, 1'b1, 3'd0, 16'h2000, 1'b1);
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "half");
    check("half_const", 80'(filtered_out), 80'h0800);
    check("half_overrun", 80'(overrun), 80'd0);

    // commit during WAIT is deferred to the sample boundary
    do_reset();
    idle_write(1'b1, 1'b0, 3'd0, 16'h2000, 1'b0);
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, "defer_a");
    check("defer_a_const", 80'(filtered_out), 80'h1000);
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "defer_b");
    check("defer_b_const", 80'(filtered_out), 80'h0800);

    // ignored selects 5..7 leave the bank untouched
    idle_write(1'b1, 1'b0, 3'd6, 16'h7fff, 1'b1);
    do_sample(16'h2000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "badsel");
    check("badsel_const", 80'(filtered_out), 80'h1000);

    // sample while busy: dropped, overrun sticky, no extra job
    do_reset();
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, "ovr");
    check("ovr_const", 80'(filtered_out), 80'h1000);
    check("ovr_flag", 80'(overrun), 80'd1);
    ov = 0;
    for (int i = 0; i < 20; i++) begin step(); if (output_valid || eng_start) ov++; end
    check("ovr_no_second_job", 80'(ov), 80'd0);
    check("ovr_sticky", 80'(overrun), 80'd1);

    // FIR tap on stage0: y = x + x1, impulse response 0x1000, 0x1000, 0
    do_reset();
    idle_write(1'b1, 1'b0, 3'd1, 16'h4000, 1'b1);
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "imp0");
    check("imp0_const", 80'(filtered_out), 80'h1000);
    do_sample(16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "imp1");
    check("imp1_const", 80'(filtered_out), 80'h1000);
    do_sample(16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "imp2");
    check("imp2_const", 80'(filtered_out), 80'h0000);

    // randomized coefficients, commits and samples against the reference
    do_reset();
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        rc = 16'($urandom_range(0, 16383)) - 16'h2000;
        idle_write(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rc,
                   $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 1) == 1) idle_write(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
      rc = 16'($urandom_range(0, 16383)) - 16'h2000;
      do_sample(16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), rc,
                1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", it));
    end

    // reset while waiting on the engine aborts the job; the late done is ignored
    do_reset();
    sample_in = 16'h1000; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (eng_start) found = 1'b1; else step();
    end
    check("abort_start_seen", 80'(found), 80'd1);
    step();
    reset = 1'b1;
    step();
    check("abort_busy", 80'(busy), 80'd0);
    check("abort_start", 80'(eng_start), 80'd0);
    check("abort_eng_x", 80'(eng_x), 80'd0);
    check("abort_eng_coef", eng_coef, 80'd0);
    reset = 1'b0;
    ref_reset();
    ov = 0;
    for (int i = 0; i < 12; i++) begin step(); if (output_valid || busy) ov++; end
    check("abort_no_output", 80'(ov), 80'd0);
    do_sample(16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "post_abort");
    check("post_abort_const", 80'(filtered_out), 80'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
